// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA framebuffer blocks.
//   - Framebuffer geometry (160x120 cells, each shown as a 4x4 pixel block).
//   - 640x480@60 timing extents (visible / total).
//   - RGB333 pixel type, packed {r,g,b} with red in the MSBs.
package vga_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  localparam int FB_ADDR_W = 15;
  localparam int CHAN_W    = 3;
  localparam int RGB_W     = 3 * CHAN_W;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb333_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: writer handshakes plus the framebuffer RAM port.
//   master: the environment (two writers and the RAM read data).
//   slave : the arbiter.
// Handshake: a writer raises i_wrN_valid and holds addr/data stable until
// the clock edge where i_wrN_valid and o_wrN_ready are both high; that edge
// is the transfer. o_wrN_ready never depends on the same writer's valid.
interface vga_fb_arbiter_if;
  import vga_pkg::*;

  logic                 i_wr0_valid;
  logic                 o_wr0_ready;
  logic [FB_ADDR_W-1:0] i_wr0_addr;
  logic [RGB_W-1:0]     i_wr0_data;

  logic                 i_wr1_valid;
  logic                 o_wr1_ready;
  logic [FB_ADDR_W-1:0] i_wr1_addr;
  logic [RGB_W-1:0]     i_wr1_data;

  logic                 o_ram_en;
  logic                 o_ram_we;
  logic [FB_ADDR_W-1:0] o_ram_addr;
  logic [RGB_W-1:0]     o_ram_wdata;
  logic [RGB_W-1:0]     i_ram_rdata;

  modport master (
    output i_wr0_valid, i_wr0_addr, i_wr0_data,
    output i_wr1_valid, i_wr1_addr, i_wr1_data,
    output i_ram_rdata,
    input  o_wr0_ready, o_wr1_ready,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );

  modport slave (
    input  i_wr0_valid, i_wr0_addr, i_wr0_data,
    input  i_wr1_valid, i_wr1_addr, i_wr1_data,
    input  i_ram_rdata,
    output o_wr0_ready, o_wr1_ready,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
  );

endinterface

// File: rtl/vga_fb_addr.sv
// vga_fb_addr: combinational screen-pixel to framebuffer-cell address.
//   i_px, i_py : pixel column/row from the sync generator.
//   o_addr     : (py/4)*160 + px/4, built from shifts and adds.
module vga_fb_addr
  import vga_pkg::*;
(
  input  logic [9:0]           i_px,
  input  logic [9:0]           i_py,
  output logic [FB_ADDR_W-1:0] o_addr
);

  logic [FB_ADDR_W-1:0] row;
  logic [FB_ADDR_W-1:0] col;
  logic [3:0]           unused_lsbs;

  assign row = {7'd0, i_py[9:2]};
  assign col = {7'd0, i_px[9:2]};

  // row*160 = row*128 + row*32; max row 131 keeps the sum inside 15 bits.
  assign o_addr = (row << 7) + (row << 5) + col;

  // The 2 LSBs select the pixel inside a 4x4 cell and do not affect the address.
  assign unused_lsbs = {i_px[1:0], i_py[1:0]};

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scanout
// and two round-robin writers.
//   i_clk, i_reset_n : pixel clock, async active-low reset.
//   i_px, i_py       : sync-generator pixel coordinates.
//   i_activeArea     : high inside the visible 640x480 region.
//   bus (slave)      : writer handshakes and the RAM port.
//   o_red/green/blue : pixel colour, 2 cycles behind i_px/i_py.
//   o_activeArea     : i_activeArea delayed 2 cycles.
// Every 4th active pixel is a scan slot that reads the cell under the beam;
// all other cycles are free for at most one write.
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [9:0]          i_px,
  input  logic [9:0]          i_py,
  input  logic                i_activeArea,
  vga_fb_arbiter_if.slave     bus,
  output logic [CHAN_W-1:0]   o_red,
  output logic [CHAN_W-1:0]   o_green,
  output logic [CHAN_W-1:0]   o_blue,
  output logic                o_activeArea
);

  logic                 scan_slot;
  logic                 free_slot;
  logic                 xfer0;
  logic                 xfer1;
  logic                 rr;
  logic                 scan_d1;
  logic                 act_d1;
  logic                 act_d2;
  rgb333_t              pix_q;
  logic [FB_ADDR_W-1:0] scan_addr;

  vga_fb_addr u_addr (
    .i_px   (i_px),
    .i_py   (i_py),
    .o_addr (scan_addr)
  );

  assign scan_slot = i_activeArea && (i_px[1:0] == 2'b00);
  // Readies are forced low while reset is held so nothing can transfer.
  assign free_slot = i_reset_n && !scan_slot;

  // Each writer only looks at the other writer's valid, never its own.
  assign bus.o_wr0_ready = free_slot && (!bus.i_wr1_valid || (rr == 1'b0));
  assign bus.o_wr1_ready = free_slot && (!bus.i_wr0_valid || (rr == 1'b1));

  assign xfer0 = bus.i_wr0_valid && bus.o_wr0_ready;
  assign xfer1 = bus.i_wr1_valid && bus.o_wr1_ready;

  always_comb begin
    bus.o_ram_en    = 1'b0;
    bus.o_ram_we    = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_wdata = '0;
    if (i_reset_n && scan_slot) begin
      bus.o_ram_en   = 1'b1;
      bus.o_ram_addr = scan_addr;
    end else if (xfer0) begin
      // Out-of-range writes still complete the handshake but never reach the RAM.
      bus.o_ram_en    = (32'(bus.i_wr0_addr) < FB_DEPTH);
      bus.o_ram_we    = 1'b1;
      bus.o_ram_addr  = bus.i_wr0_addr;
      bus.o_ram_wdata = bus.i_wr0_data;
    end else if (xfer1) begin
      bus.o_ram_en    = (32'(bus.i_wr1_addr) < FB_DEPTH);
      bus.o_ram_we    = 1'b1;
      bus.o_ram_addr  = bus.i_wr1_addr;
      bus.o_ram_wdata = bus.i_wr1_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr      <= 1'b0;
      scan_d1 <= 1'b0;
      act_d1  <= 1'b0;
      act_d2  <= 1'b0;
      pix_q   <= '0;
    end else begin
      if (xfer0) begin
        rr <= 1'b1;
      end else if (xfer1) begin
        rr <= 1'b0;
      end
      scan_d1 <= scan_slot;
      // RAM read data is valid the cycle after the scan slot.
      if (scan_d1) begin
        pix_q <= rgb333_t'(bus.i_ram_rdata);
      end
      act_d1 <= i_activeArea;
      act_d2 <= act_d1;
    end
  end

  assign o_activeArea = act_d2;
  assign o_red        = act_d2 ? pix_q.r : '0;
  assign o_green      = act_d2 ? pix_q.g : '0;
  assign o_blue       = act_d2 ? pix_q.b : '0;

endmodule
